// File: rtl/core_pkg.sv
// Shared core definitions: ALU class encodings, datapath defaults and the
// decoded control bundle carried from decode into execute.
package core_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned REG_ADDR_W_DEFAULT = 5;

  localparam logic [2:0] ALU_LDST   = 3'b000;
  localparam logic [2:0] ALU_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP     = 3'b010;
  localparam logic [2:0] ALU_JUMP   = 3'b011;
  localparam logic [2:0] ALU_AMO    = 3'b100;
  localparam logic [2:0] ALU_OPIMM  = 3'b110;
  localparam logic [2:0] ALU_NOP    = 3'b111;

  typedef struct packed {
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic [2:0] aluOp;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    branch:   1'b0,
    memRead:  1'b0,
    memToReg: 1'b0,
    aluOp:    ALU_NOP,
    memWrite: 1'b0,
    aluSrc:   1'b0,
    regWrite: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decoder fields in, registered execute fields out,
// plus the execute-side hold/flush controls and the decode stall back-pressure.
interface id_ex_stage_if #(
  parameter int unsigned XLEN       = core_pkg::XLEN_DEFAULT,
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W_DEFAULT
);

  logic                  idValid;
  logic                  idBranch;
  logic                  idMemRead;
  logic                  idMemToReg;
  logic                  idMemWrite;
  logic                  idAluSrc;
  logic                  idRegWrite;
  logic [2:0]            idAluOp;
  logic [2:0]            idFunct3;
  logic [6:0]            idFunct7;
  logic [REG_ADDR_W-1:0] idRs1;
  logic [REG_ADDR_W-1:0] idRs2;
  logic [REG_ADDR_W-1:0] idRd;
  logic                  idUsesRs1;
  logic                  idUsesRs2;
  logic [XLEN-1:0]       idRs1Data;
  logic [XLEN-1:0]       idRs2Data;
  logic [XLEN-1:0]       idImm;
  logic [XLEN-1:0]       idPc;

  logic                  exHold;
  logic                  flush;
  logic                  idStall;

  logic                  exValid;
  logic                  exBranch;
  logic                  exMemRead;
  logic                  exMemToReg;
  logic                  exMemWrite;
  logic                  exAluSrc;
  logic                  exRegWrite;
  logic [2:0]            exAluOp;
  logic [2:0]            exFunct3;
  logic [6:0]            exFunct7;
  logic [REG_ADDR_W-1:0] exRs1;
  logic [REG_ADDR_W-1:0] exRs2;
  logic [REG_ADDR_W-1:0] exRd;
  logic [XLEN-1:0]       exRs1Data;
  logic [XLEN-1:0]       exRs2Data;
  logic [XLEN-1:0]       exImm;
  logic [XLEN-1:0]       exPc;

  // Decode side: drives the instruction fields and pipeline controls.
  modport master (
    output idValid, idBranch, idMemRead, idMemToReg, idMemWrite, idAluSrc, idRegWrite,
    output idAluOp, idFunct3, idFunct7, idRs1, idRs2, idRd, idUsesRs1, idUsesRs2,
    output idRs1Data, idRs2Data, idImm, idPc, exHold, flush,
    input  idStall,
    input  exValid, exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite,
    input  exAluOp, exFunct3, exFunct7, exRs1, exRs2, exRd,
    input  exRs1Data, exRs2Data, exImm, exPc
  );

  // Pipeline register side.
  modport slave (
    input  idValid, idBranch, idMemRead, idMemToReg, idMemWrite, idAluSrc, idRegWrite,
    input  idAluOp, idFunct3, idFunct7, idRs1, idRs2, idRd, idUsesRs1, idUsesRs2,
    input  idRs1Data, idRs2Data, idImm, idPc, exHold, flush,
    output idStall,
    output exValid, exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite,
    output exAluOp, exFunct3, exFunct7, exRs1, exRs2, exRd,
    output exRs1Data, exRs2Data, exImm, exPc
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the decode slot and a load sitting in EX.
// Kept standalone so a forwarding unit can reuse the same equation.
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W_DEFAULT
) (
  input  logic                  idValid,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRd,
  output logic                  hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = idUsesRs1 && (idRs1 == exRd);
  assign rs2_match = idUsesRs2 && (idRs2 == exRd);

  // x0 is hard-wired zero, so a load targeting it never produces a value to wait for.
  assign hazard = idValid && exValid && exMemRead && (exRd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: holds on execute back-pressure, inserts bubbles
// on flush or load-use hazard, and counts inserted bubbles with a saturating counter.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] bubbleCount
);

  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
  } ex_state_t;

  // A bubble is exactly the reset image: nothing valid, ALU class NOP, all fields zero.
  function automatic ex_state_t bubble_state();
    ex_state_t s;
    s      = '0;
    s.ctrl = CTRL_BUBBLE;
    return s;
  endfunction

  ex_state_t        state_q, state_d;
  ex_state_t        id_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             bubble_ins;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .idValid   (bus.idValid),
    .idUsesRs1 (bus.idUsesRs1),
    .idUsesRs2 (bus.idUsesRs2),
    .idRs1     (bus.idRs1),
    .idRs2     (bus.idRs2),
    .exValid   (state_q.valid),
    .exMemRead (state_q.ctrl.memRead),
    .exRd      (state_q.rd),
    .hazard    (hazard)
  );

  always_comb begin
    id_state               = bubble_state();
    id_state.valid         = 1'b1;
    id_state.ctrl.branch   = bus.idBranch;
    id_state.ctrl.memRead  = bus.idMemRead;
    id_state.ctrl.memToReg = bus.idMemToReg;
    id_state.ctrl.aluOp    = bus.idAluOp;
    id_state.ctrl.memWrite = bus.idMemWrite;
    id_state.ctrl.aluSrc   = bus.idAluSrc;
    id_state.ctrl.regWrite = bus.idRegWrite;
    id_state.funct3        = bus.idFunct3;
    id_state.funct7        = bus.idFunct7;
    id_state.rs1           = bus.idRs1;
    id_state.rs2           = bus.idRs2;
    id_state.rd            = bus.idRd;
    id_state.rs1_data      = bus.idRs1Data;
    id_state.rs2_data      = bus.idRs2Data;
    id_state.imm           = bus.idImm;
    id_state.pc            = bus.idPc;
  end

  // Flush outranks hold: the killed instruction must leave EX even while EX is stalled.
  always_comb begin
    state_d    = state_q;
    bubble_ins = 1'b0;
    if (bus.flush) begin
      state_d    = bubble_state();
      bubble_ins = 1'b1;
    end else if (bus.exHold) begin
      state_d = state_q;
    end else if (hazard) begin
      state_d    = bubble_state();
      bubble_ins = 1'b1;
    end else if (bus.idValid) begin
      state_d = id_state;
    end else begin
      state_d = bubble_state();
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bubble_ins && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= bubble_state();
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.idStall    = !bus.flush && (bus.exHold || hazard);

  assign bus.exValid    = state_q.valid;
  assign bus.exBranch   = state_q.ctrl.branch;
  assign bus.exMemRead  = state_q.ctrl.memRead;
  assign bus.exMemToReg = state_q.ctrl.memToReg;
  assign bus.exMemWrite = state_q.ctrl.memWrite;
  assign bus.exAluSrc   = state_q.ctrl.aluSrc;
  assign bus.exRegWrite = state_q.ctrl.regWrite;
  assign bus.exAluOp    = state_q.ctrl.aluOp;
  assign bus.exFunct3   = state_q.funct3;
  assign bus.exFunct7   = state_q.funct7;
  assign bus.exRs1      = state_q.rs1;
  assign bus.exRs2      = state_q.rs2;
  assign bus.exRd       = state_q.rd;
  assign bus.exRs1Data  = state_q.rs1_data;
  assign bus.exRs2Data  = state_q.rs2_data;
  assign bus.exImm      = state_q.imm;
  assign bus.exPc       = state_q.pc;

  assign bubbleCount    = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the RV32 core. Sits directly downstream of the instruction control decoder and captures its control outputs together with the operand, immediate and register-index fields of the same instruction.
- Holds its contents when execute is stalled and inserts a bubble on a load-use hazard or a branch flush.
- Drives the decode-side stall and keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- idValid  in  1  decode slot holds a real instruction.
- idBranch, idMemRead, idMemToReg, idMemWrite, idAluSrc, idRegWrite  in  1 each  decoder control bits.
- idAluOp  in  3  decoder ALU class; 3'b111 is the NOP class.
- idFunct3  in  3  instruction funct3.
- idFunct7  in  7  instruction funct7.
- idRs1, idRs2, idRd  in  REG_ADDR_W each  register indices.
- idUsesRs1, idUsesRs2  in  1 each  instruction actually reads rs1 / rs2.
- idRs1Data, idRs2Data, idImm, idPc  in  XLEN each  operand values, immediate, PC.
- exHold  in  1  execute/memory cannot accept a new instruction this cycle.
- flush  in  1  taken branch or jump resolved in EX; kill the younger instruction.
- idStall  out  1  combinational; decode and fetch must hold their state this cycle.
- exValid  out  1  registered copy of idValid.
- exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite  out  1 each  registered control bits.
- exAluOp, exFunct3  out  3 each  registered.
- exFunct7  out  7  registered.
- exRs1, exRs2, exRd  out  REG_ADDR_W each  registered indices.
- exRs1Data, exRs2Data, exImm, exPc  out  XLEN each  registered.
- bubbleCount  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (rst_n low, asynchronous): every ex* output is 0 except exAluOp, which is 3'b111. bubbleCount is 0.
- A bubble state is identical to the reset state and has exValid=0.
- Load-use hazard (combinational): hazard = idValid & exValid & exMemRead & (exRd != 0) & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
- idStall = !flush & (exHold | hazard).
- Register update priority, evaluated at each rising edge:
  1. flush=1: load a bubble. This applies even when exHold=1, because the killed instruction must not stay in EX.
  2. exHold=1: keep all registers unchanged. The hazard is ignored this cycle.
  3. hazard=1: load a bubble. The decode instruction is retried next cycle and its operands are not captured.
  4. Otherwise, capture all id* inputs. If idValid=0, capture a bubble instead: control bits forced to 0 and exAluOp forced to 3'b111, so a stale control bit never reaches EX.
- Latency: one cycle from id* inputs to ex* outputs.
- Store and branch instructions are captured with their decoded exRegWrite value unchanged. Downstream gating uses exValid.
- bubbleCount increments by 1 on each edge where rule 1 or rule 3 inserted a bubble. It never counts rule 2 or idValid=0 cycles. It saturates at 2^CNT_W-1 and does not wrap.
- rd=x0 is never a hazard source.
- A hazard appears at most once per load: after the bubble, exMemRead=0, so the retried instruction proceeds next cycle.
- Reset asserted mid-stall clears everything immediately. After release, idStall reflects only the current inputs.

Decomposition:
- Shared package core_pkg:
  - ALU class constants: ALU_LDST=3'b000, ALU_BRANCH=3'b001, ALU_OP=3'b010, ALU_JUMP=3'b011, ALU_AMO=3'b100, ALU_OPIMM=3'b110, ALU_NOP=3'b111.
  - XLEN and REG_ADDR_W defaults.
  - A packed control struct {branch, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite} plus a CTRL_BUBBLE constant.
- One sub-module: load_use_detect, a purely combinational hazard equation. This keeps it reusable for a later forwarding unit.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all ex* outputs 0, exAluOp=3'b111, bubbleCount=0, without waiting for a clock edge.
- Pass-through: idValid=1, idAluOp=3'b010, idRd=5, idRs1Data=0x11 -> next edge exValid=1, exAluOp=3'b010, exRd=5, exRs1Data=0x11; idStall=0.
- Load-use: EX holds a load with exRd=7 and decode reads idRs1=7 (idUsesRs1=1) -> idStall=1, next edge bubble with exValid=0 and bubbleCount=1. On the following edge the instruction is captured and idStall=0. The same case with exRd=0 gives no stall.
- Hold: exHold=1 for 3 cycles with changing id* inputs -> ex* outputs frozen, idStall=1, bubbleCount unchanged.
- Flush during hold: exHold=1 and flush=1 together -> next edge bubble, idStall=0, bubbleCount+1.
- Saturation: with CNT_W=2, force 5 consecutive flushes -> bubbleCount sequence 1,2,3,3,3.
